// File: rtl/gic_master.sv
// gic_master: Wishbone B3 classic slave that forwards each bus operation over the
// 4-bit GIC link to a remote gic_slave and terminates the local cycle from its reply.
//
// Ports:
//   wbs_clk_i, wbs_rst_n_i      clock, asynchronous active-low reset
//   wbs_adr_i/dat_i/sel_i/we_i  request fields, latched on acceptance
//   wbs_cyc_i, wbs_stb_i        request qualifiers
//   wbs_cti_i, wbs_bte_i        ignored (classic cycles only)
//   wbs_dat_o                   read data, holds last read value
//   wbs_ack_o/err_o/rty_o       one-cycle termination pulse
//   gic_dat_o                   link nibble toward gic_slave (IDLE when not sending)
//   gic_dat_i                   link nibble from gic_slave
module gic_master #(
    parameter logic [3:0]  IDLE    = 4'b1111,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        wbs_clk_i,
    input  logic        wbs_rst_n_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic [2:0]  wbs_cti_i,
    input  logic [1:0]  wbs_bte_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        wbs_rty_o,
    output logic [3:0]  gic_dat_o,
    input  logic [3:0]  gic_dat_i
);

    typedef enum logic [3:0] {
        StIdle, StTxInit, StTxCmd, StTxSel, StTxAdr, StTxDat, StTxCksum,
        StRxWait, StRxResp, StRxDat, StRxCksum, StDone
    } state_e;

    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    // Termination codes, {rty, err, ack}
    localparam logic [2:0] TERM_ACK = 3'b001;
    localparam logic [2:0] TERM_ERR = 3'b010;
    localparam logic [2:0] TERM_RTY = 3'b100;

    state_e            r_state, w_state_nxt;
    logic [3:0]        r_gic, w_gic_nxt;
    logic [2:0]        r_cnt, w_cnt_nxt;
    logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;
    logic [31:0]       r_adr, w_adr_nxt;
    logic [31:0]       r_wdat, w_wdat_nxt;
    logic [3:0]        r_sel, w_sel_nxt;
    logic              r_we, w_we_nxt;
    logic [3:0]        r_cksum, w_cksum_nxt;
    logic [31:0]       r_rdat, w_rdat_nxt;
    logic [2:0]        r_term, w_term_nxt;
    logic              r_abort, w_abort_nxt;
    logic              r_ack, r_err, r_rty;
    logic [2:0]        w_pulse_nxt;
    logic [31:0]       r_dat_o, w_dat_o_nxt;
    logic              w_req;
    logic              w_rd_load;
    logic              w_unused;

    assign w_req    = wbs_cyc_i & wbs_stb_i;
    assign w_unused = ^{wbs_cti_i, wbs_bte_i};

    // XOR of the eight nibbles of a word
    function automatic logic [3:0] fold(input logic [31:0] w);
        logic [3:0] acc;
        acc = 4'h0;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ w[4*i +: 4];
        end
        return acc;
    endfunction

    // The last nibble of every 8-nibble group carries an extra 4'b1100
    function automatic logic [3:0] tx_cksum(input logic [3:0] sel, input logic [31:0] adr,
                                            input logic [31:0] dat, input logic we);
        logic [3:0] c;
        c = sel ^ fold(adr) ^ 4'hC;
        if (we) begin
            c = c ^ fold(dat) ^ 4'hC;
        end
        return c;
    endfunction

    function automatic logic [2:0] decode_status(input logic [3:0] n);
        logic [2:0] t;
        unique case (n)
            4'b0001: t = TERM_ACK;
            4'b0010: t = TERM_ERR;
            4'b0100: t = TERM_RTY;
            default: t = TERM_ERR;
        endcase
        return t;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_gic_nxt   = IDLE;
        w_cnt_nxt   = r_cnt;
        w_tmo_nxt   = r_tmo;
        w_adr_nxt   = r_adr;
        w_wdat_nxt  = r_wdat;
        w_sel_nxt   = r_sel;
        w_we_nxt    = r_we;
        w_cksum_nxt = r_cksum;
        w_rdat_nxt  = r_rdat;
        w_term_nxt  = r_term;
        w_pulse_nxt = 3'b000;
        w_dat_o_nxt = r_dat_o;
        w_rd_load   = 1'b0;
        // Once the master lets go, this operation never terminates on the bus
        w_abort_nxt = r_abort | ((r_state != StIdle) & ~w_req);

        case (r_state)
            StIdle: begin
                w_abort_nxt = 1'b0;
                if (w_req) begin
                    w_adr_nxt   = wbs_adr_i;
                    w_wdat_nxt  = wbs_dat_i;
                    w_sel_nxt   = wbs_sel_i;
                    w_we_nxt    = wbs_we_i;
                    w_cksum_nxt = tx_cksum(wbs_sel_i, wbs_adr_i, wbs_dat_i, wbs_we_i);
                    w_gic_nxt   = 4'b1010;
                    w_state_nxt = StTxInit;
                end
            end
            StTxInit: begin
                w_gic_nxt   = {r_we, 3'b000};
                w_state_nxt = StTxCmd;
            end
            StTxCmd: begin
                w_gic_nxt   = r_sel;
                w_state_nxt = StTxSel;
            end
            StTxSel: begin
                w_gic_nxt   = r_adr[31:28];
                w_cnt_nxt   = 3'd0;
                w_state_nxt = StTxAdr;
            end
            StTxAdr: begin
                if (r_cnt == 3'd7) begin
                    if (r_we) begin
                        w_gic_nxt   = r_wdat[31:28];
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = StTxDat;
                    end else begin
                        w_gic_nxt   = r_cksum;
                        w_state_nxt = StTxCksum;
                    end
                end else begin
                    w_adr_nxt = {r_adr[27:0], 4'h0};
                    w_gic_nxt = r_adr[27:24];
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            StTxDat: begin
                if (r_cnt == 3'd7) begin
                    w_gic_nxt   = r_cksum;
                    w_state_nxt = StTxCksum;
                end else begin
                    w_wdat_nxt = {r_wdat[27:0], 4'h0};
                    w_gic_nxt  = r_wdat[27:24];
                    w_cnt_nxt  = r_cnt + 3'd1;
                end
            end
            StTxCksum: begin
                w_tmo_nxt   = '0;
                w_state_nxt = StRxWait;
            end
            StRxWait: begin
                if (gic_dat_i == 4'b0101) begin
                    w_state_nxt = StRxResp;
                end else if ((TIMEOUT != 0) && (r_tmo == TMO_LAST)) begin
                    w_term_nxt  = TERM_ERR;
                    w_state_nxt = StDone;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            StRxResp: begin
                w_term_nxt = decode_status(gic_dat_i);
                w_cnt_nxt  = 3'd0;
                w_state_nxt = r_we ? StDone : StRxDat;
            end
            StRxDat: begin
                w_rdat_nxt = {r_rdat[27:0], gic_dat_i};
                if (r_cnt == 3'd7) begin
                    w_state_nxt = StRxCksum;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            StRxCksum: begin
                if (gic_dat_i != (fold(r_rdat) ^ 4'hC)) begin
                    w_term_nxt = TERM_ERR;
                end
                w_rd_load   = 1'b1;
                w_state_nxt = StDone;
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // Outputs are registered, so the pulse is scheduled on entry to StDone
        if ((w_state_nxt == StDone) && (r_state != StDone) && !w_abort_nxt) begin
            w_pulse_nxt = w_term_nxt;
            if (w_rd_load) begin
                w_dat_o_nxt = r_rdat;
            end
        end
    end

    always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
        if (!wbs_rst_n_i) begin
            r_state <= StIdle;
            r_gic   <= IDLE;
            r_cnt   <= 3'd0;
            r_tmo   <= '0;
            r_adr   <= 32'h0;
            r_wdat  <= 32'h0;
            r_sel   <= 4'h0;
            r_we    <= 1'b0;
            r_cksum <= 4'h0;
            r_rdat  <= 32'h0;
            r_term  <= 3'b000;
            r_abort <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rty   <= 1'b0;
            r_dat_o <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_gic   <= w_gic_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tmo   <= w_tmo_nxt;
            r_adr   <= w_adr_nxt;
            r_wdat  <= w_wdat_nxt;
            r_sel   <= w_sel_nxt;
            r_we    <= w_we_nxt;
            r_cksum <= w_cksum_nxt;
            r_rdat  <= w_rdat_nxt;
            r_term  <= w_term_nxt;
            r_abort <= w_abort_nxt;
            r_ack   <= w_pulse_nxt[0];
            r_err   <= w_pulse_nxt[1];
            r_rty   <= w_pulse_nxt[2];
            r_dat_o <= w_dat_o_nxt;
        end
    end

    assign wbs_dat_o = r_dat_o;
    assign wbs_ack_o = r_ack;
    assign wbs_err_o = r_err;
    assign wbs_rty_o = r_rty;
    assign gic_dat_o = r_gic;

endmodule

// File: tb/tb_gic_master.sv
// tb_gic_master: scoreboard bench for gic_master. Expected link frames and bus
// terminations are queued as each request is issued and retired as the DUT emits them.
module tb_gic_master;

    typedef struct packed {
        logic [2:0]  term;   // {rty, err, ack}
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr, wdat, rdat;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic        ack, err, rty;
    logic [3:0]  gic_out;
    logic [3:0]  gic_in = 4'hF;

    logic [3:0]  q_tx[$];
    logic [3:0]  q_rx[$];
    exp_t        q_term[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pulses   = 0;
    int          cyc_cnt  = 0;
    int          t_rxwait = 0;
    int          t_term   = 0;
    logic        tx_arm   = 1'b0;

    always #5 clk = ~clk;

    gic_master #(
        .IDLE    (4'b1111),
        .TIMEOUT (16)
    ) u_dut (
        .wbs_clk_i   (clk),
        .wbs_rst_n_i (rst_n),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (wdat),
        .wbs_sel_i   (sel),
        .wbs_we_i    (we),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_cti_i   (3'b000),
        .wbs_bte_i   (2'b00),
        .wbs_dat_o   (rdat),
        .wbs_ack_o   (ack),
        .wbs_err_o   (err),
        .wbs_rty_o   (rty),
        .gic_dat_o   (gic_out),
        .gic_dat_i   (gic_in)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc_cnt++;

    // Response driver: one nibble per cycle, changed just after the edge
    always @(posedge clk) begin
        #1;
        if (q_rx.size() > 0) gic_in = q_rx.pop_front();
    end

    // Output monitor
    always @(negedge clk) begin
        logic [3:0] nib;
        exp_t       e;
        if (tx_arm && q_tx.size() > 0) begin
            nib = q_tx.pop_front();
            check("gic_tx", 32'(gic_out), 32'(nib));
            if (q_tx.size() == 0) t_rxwait = cyc_cnt;
        end
        if (ack | err | rty) begin
            pulses++;
            t_term = cyc_cnt;
            if (q_term.size() == 0) begin
                check("unexp_term", {29'b0, rty, err, ack}, 32'h0);
            end else begin
                e = q_term.pop_front();
                check("term", {29'b0, rty, err, ack}, {29'b0, e.term});
                check("rdata", rdat, e.dat);
            end
        end
    end

    // Independent frame model: header, cmd, sel, adr, [dat], checksum, then idle
    task automatic build_frame(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s);
        logic [3:0] ck;
        q_tx.delete();
        q_tx.push_back(4'hA);
        q_tx.push_back({w, 3'b000});
        q_tx.push_back(s);
        ck = s;
        for (int i = 7; i >= 0; i--) begin
            q_tx.push_back(a[4*i +: 4]);
            ck = ck ^ a[4*i +: 4];
        end
        ck = ck ^ 4'hC;
        if (w) begin
            for (int i = 7; i >= 0; i--) begin
                q_tx.push_back(d[4*i +: 4]);
                ck = ck ^ d[4*i +: 4];
            end
            ck = ck ^ 4'hC;
        end
        q_tx.push_back(ck);
        q_tx.push_back(4'hF);
    endtask

    task automatic do_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] term,
                         input logic [31:0] exp_dat, input logic push_term);
        exp_t e;
        build_frame(w, a, d, s);
        if (push_term) begin
            e.term = term;
            e.dat  = exp_dat;
            q_term.push_back(e);
        end
        @(posedge clk);
        #1;
        adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        tx_arm = 1'b1;
        for (int i = 0; i < 40 && q_tx.size() != 0; i++) @(posedge clk);
        check("tx_done", 32'(q_tx.size()), 32'h0);
        tx_arm = 1'b0;
        q_tx.delete();
    endtask

    task automatic wait_term();
        for (int i = 0; i < 200 && q_term.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (q_term.size() != 0) begin
            check("term_wait", 32'(q_term.size()), 32'h0);
            q_term.delete();
        end
        cyc = 1'b0;
        stb = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] st_nib[4];
        logic [2:0] st_exp[4];
        int         p0;
        st_nib = '{4'h4, 4'h2, 4'h3, 4'h0};
        st_exp = '{3'b100, 3'b010, 3'b010, 3'b010};

        rst_n = 1'b0;
        adr = '0; wdat = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gic", 32'(gic_out), 32'hF);
        check("rst_ack", {29'b0, rty, err, ack}, 32'h0);
        check("rst_dat", rdat, 32'h0);
        rst_n = 1'b1;

        // Write, acked after three idle response cycles
        do_op(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b001, 32'h0, 1'b1);
        q_rx = '{4'hF, 4'hF, 4'hF, 4'h5, 4'h1, 4'hF};
        wait_term();
        check("wr_pulses", 32'(pulses), 32'd1);

        // Read, good checksum
        do_op(1'b0, 32'h0000_0004, 32'h0, 4'hF, 3'b001, 32'h1234_5678, 1'b1);
        q_rx = '{4'h5, 4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h4, 4'hF};
        wait_term();

        // Read, bad checksum overrides the ack status
        do_op(1'b0, 32'h0000_0004, 32'h0, 4'hF, 3'b010, 32'h1234_5678, 1'b1);
        q_rx = '{4'h5, 4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h5, 4'hF};
        wait_term();

        // Status variants on writes; read data must stay put
        for (int i = 0; i < 4; i++) begin
            do_op(1'b1, 32'h0000_0100 + 32'(i), 32'hA5A5_0000 + 32'(i), 4'h3, st_exp[i],
                  32'h1234_5678, 1'b1);
            q_rx = '{4'h5, st_nib[i], 4'hF};
            wait_term();
        end

        // Timeout: no response at all
        do_op(1'b1, 32'h0000_0020, 32'h55AA_55AA, 4'hC, 3'b010, 32'h1234_5678, 1'b1);
        wait_term();
        check("tmo_lat", 32'(t_term - t_rxwait), 32'd16);
        do_op(1'b1, 32'h0000_0024, 32'h0BAD_F00D, 4'hF, 3'b001, 32'h1234_5678, 1'b1);
        q_rx = '{4'h5, 4'h1, 4'hF};
        wait_term();

        // Reset while the address is going out
        p0 = pulses;
        build_frame(1'b1, 32'hCAFE_0000, 32'h1111_2222, 4'hF);
        @(posedge clk);
        #1;
        adr = 32'hCAFE_0000; wdat = 32'h1111_2222; sel = 4'hF; we = 1'b1;
        cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        tx_arm = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rst_n  = 1'b0;
        tx_arm = 1'b0;
        q_tx.delete();
        #1;
        check("rst_mid_gic", 32'(gic_out), 32'hF);
        cyc = 1'b0;
        stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_nopulse", 32'(pulses - p0), 32'h0);
        rst_n = 1'b1;
        do_op(1'b1, 32'h0000_0030, 32'h0102_0304, 4'h5, 3'b001, 32'h0, 1'b1);
        q_rx = '{4'h5, 4'h1, 4'hF};
        wait_term();

        // Master drops the cycle while the response is outstanding
        p0 = pulses;
        do_op(1'b1, 32'h0000_0040, 32'hFEED_FACE, 4'hF, 3'b001, 32'h0, 1'b0);
        cyc = 1'b0;
        stb = 1'b0;
        q_rx = '{4'h5, 4'h1, 4'hF};
        repeat (10) @(posedge clk);
        check("abort_nopulse", 32'(pulses - p0), 32'h0);
        do_op(1'b1, 32'h0000_0044, 32'h7777_8888, 4'hF, 3'b001, 32'h0, 1'b1);
        q_rx = '{4'h5, 4'h1, 4'hF};
        wait_term();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
